address_generator_w_tiled: RTL and testbench

Parametrised weight-buffer address generator for the systolic array: the successor to the fixed single-pass W-side generator. On a start pulse it walks a tile of `num_rows` weight rows for up to `ARRAY_M` columns with a programmable row stride, and emits one address and one enable per column. In WS mode it drives all active columns together (preload). In OS mode it drives them with a per-column diagonal skew. It sits between the controller FSM and the per-column weight BRAM read ports.

---
 rtl/address_generator_w_tiled.sv | 150 +++++++++++++++
 tb/tb_address_generator_w_tiled.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/address_generator_w_tiled.sv
// Weight-buffer tile address generator: WS preload (all lanes together) or OS diagonal skew.
// Optional stall input enabled by defining ADDR_GEN_W_PAUSE_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs cleared
// RUN   | emitting one registered step per cycle
// FIN   | last step on the bus; done pulses on the following cycle
module address_generator_w_tiled #(
    parameter int ADDR_WIDTH = 16,
    parameter int ARRAY_M    = 8,
    parameter int ROW_WIDTH  = 8,
    localparam int CONCAT_ADDR_WIDTH = ADDR_WIDTH * ARRAY_M
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [$clog2(ARRAY_M):0]     num_cols,
    input  logic [ROW_WIDTH-1:0]         num_rows,
    input  logic [ROW_WIDTH-1:0]         row_stride,
    input  logic                         pause,
    output logic                         busy,
    output logic                         done,
    output logic [CONCAT_ADDR_WIDTH-1:0] address,
    output logic [ARRAY_M-1:0]           enable
);

    localparam int COL_W  = $clog2(ARRAY_M) + 1;
    localparam int STEP_W = ROW_WIDTH + COL_W;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                 state_q, state_d;
    logic                   mode_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [COL_W-1:0]       cols_q;
    logic [ROW_WIDTH-1:0]   rows_q;
    logic [ROW_WIDTH-1:0]   stride_q;
    logic [STEP_W-1:0]      t_q;
    logic [STEP_W-1:0]      left_q;
    logic [ADDR_WIDTH-1:0]  row_off_q;
    logic                   done_q;
    logic [CONCAT_ADDR_WIDTH-1:0] address_q, addr_d;
    logic [ARRAY_M-1:0]     enable_q, en_d;
    logic [ADDR_WIDTH-1:0]  lane_val;
    logic [COL_W-1:0]       cols_clamped;
    logic [STEP_W-1:0]      len_m1;
    logic                   zero_tile;
    logic                   stall;

`ifdef ADDR_GEN_W_PAUSE_EN
    assign stall = pause && (state_q == RUN);
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign stall = 1'b0;
`endif

    assign cols_clamped = (num_cols > COL_W'(ARRAY_M)) ? COL_W'(ARRAY_M) : num_cols;
    assign zero_tile    = (num_cols == '0) || (num_rows == '0);
    // Step down-counter preload: L-1 for the tile being latched
    assign len_m1 = mode ? (STEP_W'(num_rows) + STEP_W'(cols_clamped) - STEP_W'(2))
                         : (STEP_W'(num_rows) - STEP_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = zero_tile ? FIN : RUN;
            RUN:  if (!stall && (left_q == '0)) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // row_off_q holds t*stride; OS lanes subtract c*stride to get (t-c)*stride
    always_comb begin
        addr_d   = '0;
        en_d     = '0;
        lane_val = '0;
        for (int c = 0; c < ARRAY_M; c++) begin
            if (COL_W'(c) < cols_q) begin
                lane_val = base_q + row_off_q + ADDR_WIDTH'(c)
                         - (mode_q ? ADDR_WIDTH'(c) * ADDR_WIDTH'(stride_q) : '0);
                if (!mode_q || ((STEP_W'(c) <= t_q) &&
                                (t_q < STEP_W'(c) + STEP_W'(rows_q)))) begin
                    en_d[c] = 1'b1;
                    addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] = lane_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            base_q    <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            stride_q  <= '0;
            t_q       <= '0;
            left_q    <= '0;
            row_off_q <= '0;
            done_q    <= 1'b0;
            address_q <= '0;
            enable_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    address_q <= '0;
                    enable_q  <= '0;
                    if (start) begin
                        mode_q    <= mode;
                        base_q    <= base_addr;
                        cols_q    <= cols_clamped;
                        rows_q    <= num_rows;
                        stride_q  <= row_stride;
                        t_q       <= '0;
                        left_q    <= len_m1;
                        row_off_q <= '0;
                    end
                end
                RUN: begin
                    if (stall) begin
                        enable_q <= '0;
                    end else begin
                        address_q <= addr_d;
                        enable_q  <= en_d;
                        t_q       <= t_q + STEP_W'(1);
                        left_q    <= left_q - STEP_W'(1);
                        row_off_q <= row_off_q + ADDR_WIDTH'(stride_q);
                    end
                end
                default: begin
                    address_q <= '0;
                    enable_q  <= '0;
                end
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign address = address_q;
    assign enable  = enable_q;

endmodule

// File: tb/tb_address_generator_w_tiled.sv
// Bench for address_generator_w_tiled: vector table with a per-cycle expected-output queue,
// plus hand sequences for OS skew, address wrap and mid-tile reset.
module tb_address_generator_w_tiled;

    localparam int AW  = 16;
    localparam int M   = 8;
    localparam int RW  = 8;
    localparam int CW  = $clog2(M) + 1;
    localparam int CAW = AW * M;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           mode = 1'b0;
    logic           start = 1'b0;
    logic           pause = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [CW-1:0]  num_cols = '0;
    logic [RW-1:0]  num_rows = '0;
    logic [RW-1:0]  row_stride = '0;
    logic           busy, done;
    logic [CAW-1:0] address;
    logic [M-1:0]   enable;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    address_generator_w_tiled #(.ADDR_WIDTH(AW), .ARRAY_M(M), .ROW_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start),
        .base_addr(base_addr), .num_cols(num_cols), .num_rows(num_rows),
        .row_stride(row_stride), .pause(pause),
        .busy(busy), .done(done), .address(address), .enable(enable)
    );

    typedef struct packed {
        logic           busy;
        logic           done;
        logic [M-1:0]   en;
        logic [CAW-1:0] addr;
    } obs_t;

    typedef struct {
        logic           md;
        logic [AW-1:0]  base;
        logic [CW-1:0]  cols;
        logic [RW-1:0]  rows;
        logic [RW-1:0]  stride;
        int             pause_at;
        int             pause_len;
        int             dup_at;
    } vec_t;

    obs_t exp_q[$];

    function automatic obs_t model_step(input logic md, input logic [AW-1:0] base, input int cols,
                                        input int rows, input logic [RW-1:0] stride, input int t);
        obs_t o;
        int r;
        logic [31:0] a;
        o = '0;
        o.busy = 1'b1;
        for (int c = 0; c < cols; c++) begin
            r = md ? t - c : t;
            if (r >= 0 && r < rows) begin
                a = 32'(base) + 32'(r) * 32'(stride) + 32'(c);
                o.en[c] = 1'b1;
                o.addr[c*AW +: AW] = a[AW-1:0];
            end
        end
        return o;
    endfunction

    function automatic bit paused_at(input vec_t v, input int i);
`ifdef ADDR_GEN_W_PAUSE_EN
        return (i >= v.pause_at) && (i < v.pause_at + v.pause_len);
`else
        return (v.pause_at < -1000) && (i < -1000);
`endif
    endfunction

    task automatic push_tile(input vec_t v);
        int cols, rows, len, t, i;
        obs_t o, last;
        cols = (int'(v.cols) > M) ? M : int'(v.cols);
        rows = int'(v.rows);
        len  = (cols == 0 || rows == 0) ? 0 : (v.md ? rows + cols - 1 : rows);
        o = '0;
        o.busy = 1'b1;
        exp_q.push_back(o);
        last = '0;
        t = 0;
        i = 1;
        while (t < len) begin
            if (paused_at(v, i)) begin
                o = last;
                o.busy = 1'b1;
                o.en = '0;
            end else begin
                o = model_step(v.md, v.base, cols, rows, v.stride, t);
                last = o;
                t++;
            end
            exp_q.push_back(o);
            i++;
        end
        o = '0;
        o.done = 1'b1;
        exp_q.push_back(o);
    endtask

    task automatic tick(input int id, input int i);
        obs_t e, a;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {busy, done, enable, address};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL tile%0d cyc%0d: got busy=%b done=%b en=%h addr=%h, want busy=%b done=%b en=%h addr=%h",
                         id, i, a.busy, a.done, a.en, a.addr, e.busy, e.done, e.en, e.addr);
            end
        end
    endtask

    task automatic run_tile(input vec_t v, input int id);
        int i;
        push_tile(v);
        mode = v.md; base_addr = v.base; num_cols = v.cols;
        num_rows = v.rows; row_stride = v.stride;
        i = 0;
        while (exp_q.size() > 0 && i < 500) begin
            start = (i == 0) || (i == v.dup_at);
            pause = (i >= v.pause_at) && (i < v.pause_at + v.pause_len);
            if (i > 0) begin
                base_addr  = AW'($urandom);
                num_rows   = RW'($urandom);
                row_stride = RW'($urandom);
                mode       = ~v.md;
            end
            tick(id, i);
            i++;
        end
        start = 1'b0;
        pause = 1'b0;
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL tile%0d timeout: %0d expected cycles left", id, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic raw_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [CAW-1:0] act, input logic [CAW-1:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    vec_t vecs[12];
    logic [M-1:0]  os_en[6] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h0C, 8'h08};
    logic [AW-1:0] wrap_a[3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    initial begin
        //            md    base      cols rows stride p_at p_len dup
        vecs[0]  = '{1'b0, 16'h0000, 4'd8,  8'd4, 8'd8,   -1, 0, -1};
        vecs[1]  = '{1'b1, 16'h0100, 4'd4,  8'd3, 8'd4,   -1, 0, -1};
        vecs[2]  = '{1'b0, 16'h0040, 4'd12, 8'd2, 8'd3,   -1, 0, -1};
        vecs[3]  = '{1'b1, 16'h1000, 4'd12, 8'd2, 8'd5,   -1, 0, -1};
        vecs[4]  = '{1'b0, 16'h0010, 4'd8,  8'd0, 8'd1,   -1, 0, -1};
        vecs[5]  = '{1'b1, 16'h0010, 4'd0,  8'd5, 8'd1,   -1, 0, -1};
        vecs[6]  = '{1'b0, 16'hFFFE, 4'd1,  8'd3, 8'd1,   -1, 0, -1};
        vecs[7]  = '{1'b1, 16'h0200, 4'd8,  8'd8, 8'd8,   -1, 0,  4};
        vecs[8]  = '{1'b0, 16'h0000, 4'd8,  8'd4, 8'd8,    2, 2, -1};
        vecs[9]  = '{1'b1, 16'h0300, 4'd3,  8'd2, 8'd2,    0, 2, -1};
        vecs[10] = '{1'b0, 16'h0500, 4'd2,  8'd2, 8'd7,    3, 1, -1};
        vecs[11] = '{1'b1, 16'hFFF0, 4'd8,  8'd1, 8'hFF,  -1, 0, -1};

        reset = 1'b0;
        repeat (3) raw_tick();
        chk("reset_state", CAW'({busy, done, enable, address}), '0);
        reset = 1'b1;
        raw_tick();

        // Consecutive tiles start in the done cycle of the previous one
        for (int k = 0; k < 12; k++) run_tile(vecs[k], k);

        // OS 4x3 skew, checked against literal enable patterns
        mode = 1'b1; base_addr = 16'h0100; num_cols = 4'd4; num_rows = 8'd3; row_stride = 8'd4;
        start = 1'b1;
        raw_tick();
        start = 1'b0;
        for (int t = 0; t < 6; t++) begin
            raw_tick();
            chk($sformatf("os_en_step%0d", t), CAW'(enable), CAW'(os_en[t]));
            if (t == 2) chk("os_step2_lane1", CAW'(address[1*AW +: AW]), CAW'(16'h0105));
        end
        raw_tick();
        chk("os_done_cycle", CAW'({busy, done, enable}), CAW'({1'b0, 1'b1, 8'h00}));

        // WS single-column wrap
        mode = 1'b0; base_addr = 16'hFFFE; num_cols = 4'd1; num_rows = 8'd3; row_stride = 8'd1;
        start = 1'b1;
        raw_tick();
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            raw_tick();
            chk($sformatf("wrap_step%0d", t), CAW'({enable, address[AW-1:0]}), CAW'({8'h01, wrap_a[t]}));
        end
        raw_tick();

        // Asynchronous reset in the middle of an OS 8x8 tile
        mode = 1'b1; base_addr = 16'h0000; num_cols = 4'd8; num_rows = 8'd8; row_stride = 8'd8;
        start = 1'b1;
        raw_tick();
        start = 1'b0;
        repeat (4) raw_tick();
        chk("midrun_active", CAW'(busy && (enable != '0)), CAW'(1));
        #2 reset = 1'b0;
        #1;
        chk("midrun_reset_clear", CAW'({busy, done, enable, address}), '0);
        raw_tick();
        chk("reset_no_done", CAW'({busy, done}), '0);
        reset = 1'b1;
        raw_tick();
        run_tile(vecs[1], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
